// File: rtl/dmfb_arb_pkg.sv
// Shared types and defaults for the DMFB move arbiter.
package dmfb_arb_pkg;

    localparam int ARB_NUM_REQ     = 2;
    localparam int ARB_CELL_W      = 4;
    localparam int ARB_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MOVE,
        S_DONE,
        S_ABORT
    } arb_state_t;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmfb_rr_picker.sv
// Two-way round-robin select: on a tie the requester not served last wins.
module dmfb_rr_picker (
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       idx
);

    assign valid = |req;

    always_comb begin
        idx = req[1];
        if (req == 2'b11) idx = ~last;
    end

endmodule

// File: rtl/dmfb_move_arbiter.sv
// Arbitrates two droplet requesters onto a single move datapath.
// Optional watchdog abort enabled by defining DMFB_ARB_WATCHDOG_EN.
module dmfb_move_arbiter
    import dmfb_arb_pkg::*;
#(
    parameter int NUM_REQ     = ARB_NUM_REQ,
    parameter int CELL_W      = ARB_CELL_W,
    parameter int TIMEOUT_CYC = ARB_TIMEOUT_CYC
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [CELL_W-1:0]  src0,
    input  logic [CELL_W-1:0]  dest0,
    input  logic [CELL_W-1:0]  src1,
    input  logic [CELL_W-1:0]  dest1,
    input  logic               reachDest,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] err,
    output logic [CELL_W-1:0]  gen_src,
    output logic [CELL_W-1:0]  gen_dest,
    output logic               gen_enable,
    output logic               gen_reset,
    output logic               busy
);

    if (NUM_REQ != 2 || TIMEOUT_CYC < 2) begin : g_param_chk
        $error("dmfb_move_arbiter: NUM_REQ must be 2 and TIMEOUT_CYC >= 2");
    end

    arb_state_t state, state_d;
    logic       owner, owner_d;
    logic       last_served;
    logic       pick_vld, pick_idx;
    logic       wd_expire;

    dmfb_rr_picker u_picker (
        .req   (req),
        .last  (last_served),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

`ifdef DMFB_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    logic [WD_W-1:0] wd_cnt;

    // Saturating count; the abort compare fires before saturation matters.
    always_ff @(posedge clock) begin
        if (reset)                               wd_cnt <= '0;
        else if (state == S_LOAD)                wd_cnt <= '0;
        else if (state == S_MOVE && wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock) begin
        if (reset) err <= '0;
        else       err <= (state_d == S_ABORT) ? onehot2(owner_d) : '0;
    end
`else
    assign wd_expire = 1'b0;
    assign err       = '0;
`endif

    always_comb begin
        state_d = state;
        owner_d = owner;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_LOAD;
                    owner_d = pick_idx;
                end
            end
            // Addresses were latched on entry, so compare the held copies.
            S_LOAD:  state_d = (gen_src == gen_dest) ? S_DONE : S_MOVE;
            S_MOVE: begin
                if (reachDest)      state_d = S_DONE;
                else if (wd_expire) state_d = S_ABORT;
            end
            S_DONE:  state_d = S_IDLE;
            S_ABORT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            owner       <= 1'b0;
            last_served <= 1'b1;
            grant       <= '0;
            done        <= '0;
            gen_enable  <= 1'b0;
            gen_reset   <= 1'b0;
            busy        <= 1'b0;
            gen_src     <= '0;
            gen_dest    <= '0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            grant      <= (state_d == S_LOAD || state_d == S_MOVE) ? onehot2(owner_d) : '0;
            done       <= (state_d == S_DONE) ? onehot2(owner_d) : '0;
            gen_enable <= (state_d == S_MOVE);
            gen_reset  <= (state_d == S_LOAD);
            busy       <= (state_d != S_IDLE);
            if (state == S_IDLE && pick_vld) begin
                gen_src  <= pick_idx ? src1  : src0;
                gen_dest <= pick_idx ? dest1 : dest0;
            end
            if (state_d == S_DONE || state_d == S_ABORT)
                last_served <= owner_d;
        end
    end

endmodule

// File: tb/tb_dmfb_move_arbiter.sv
// Directed bench for dmfb_move_arbiter: vector table plus corner-case sequences.
module tb_dmfb_move_arbiter;

    logic       clock, reset;
    logic [1:0] req;
    logic [3:0] src0, dest0, src1, dest1;
    logic       reachDest;
    logic [1:0] grant, done, err;
    logic [3:0] gen_src, gen_dest;
    logic       gen_enable, gen_reset, busy;

    int tests = 0;
    int fails = 0;

    dmfb_move_arbiter #(.NUM_REQ(2), .CELL_W(4), .TIMEOUT_CYC(16)) dut (
        .clock(clock), .reset(reset), .req(req),
        .src0(src0), .dest0(dest0), .src1(src1), .dest1(dest1),
        .reachDest(reachDest), .grant(grant), .done(done), .err(err),
        .gen_src(gen_src), .gen_dest(gen_dest), .gen_enable(gen_enable),
        .gen_reset(gen_reset), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [3:0] s0, d0, s1, d1;
        logic       rd;
        logic [1:0] g, dn;
        logic       en, gr, bz;
        logic [3:0] gs, gd;
    } vec_t;

    function automatic vec_t mk(logic rst, logic [1:0] rq, logic [3:0] s0, logic [3:0] d0,
                                logic [3:0] s1, logic [3:0] d1, logic rd,
                                logic [1:0] g, logic [1:0] dn, logic en, logic gr,
                                logic bz, logic [3:0] gs, logic [3:0] gd);
        vec_t v;
        v.rst = rst; v.req = rq; v.s0 = s0; v.d0 = d0; v.s1 = s1; v.d1 = d1; v.rd = rd;
        v.g = g; v.dn = dn; v.en = en; v.gr = gr; v.bz = bz; v.gs = gs; v.gd = gd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [31:0] outs();
        return {15'd0, grant, done, gen_enable, gen_reset, busy, gen_src, gen_dest, err};
    endfunction

    function automatic logic [31:0] expv(vec_t v);
        return {15'd0, v.g, v.dn, v.en, v.gr, v.bz, v.gs, v.gd, 2'b00};
    endfunction

    vec_t tbl[12];
    logic [1:0] exp_g[9];
    logic [1:0] exp_d[9];

    initial begin
        reset = 1'b1; req = 2'b00; reachDest = 1'b0;
        src0 = 4'd0; dest0 = 4'd0; src1 = 4'd0; dest1 = 4'd0;

        //          rst req s0 d0 s1 d1 rd | g     dn    en gr bz gs gd
        tbl[0]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 2'b01, 2, 7, 0, 0, 0, 2'b01, 2'b00, 0, 1, 1, 2, 7);
        tbl[2]  = mk(0, 2'b01, 2, 7, 0, 0, 0, 2'b01, 2'b00, 1, 0, 1, 2, 7);
        tbl[3]  = mk(0, 2'b01, 2, 7, 0, 0, 0, 2'b01, 2'b00, 1, 0, 1, 2, 7);
        tbl[4]  = mk(0, 2'b01, 2, 7, 0, 0, 0, 2'b01, 2'b00, 1, 0, 1, 2, 7);
        tbl[5]  = mk(0, 2'b01, 2, 7, 0, 0, 0, 2'b01, 2'b00, 1, 0, 1, 2, 7);
        tbl[6]  = mk(0, 2'b01, 2, 7, 0, 0, 0, 2'b01, 2'b00, 1, 0, 1, 2, 7);
        tbl[7]  = mk(0, 2'b01, 2, 7, 0, 0, 1, 2'b00, 2'b01, 0, 0, 1, 2, 7);
        tbl[8]  = mk(0, 2'b00, 2, 7, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 2, 7);
        tbl[9]  = mk(0, 2'b10, 2, 7, 9, 9, 0, 2'b10, 2'b00, 0, 1, 1, 9, 9);
        tbl[10] = mk(0, 2'b10, 2, 7, 9, 9, 0, 2'b00, 2'b10, 0, 0, 1, 9, 9);
        tbl[11] = mk(0, 2'b00, 2, 7, 9, 9, 0, 2'b00, 2'b00, 0, 0, 0, 9, 9);

        exp_g = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b01};
        exp_d = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};

        // Reset, single move with 5 MOVE cycles, then a zero-length move.
        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst; req = tbl[i].req; reachDest = tbl[i].rd;
            src0 = tbl[i].s0; dest0 = tbl[i].d0; src1 = tbl[i].s1; dest1 = tbl[i].d1;
            step();
            chk($sformatf("vec%0d", i), outs(), expv(tbl[i]));
        end

        // Both requesting continuously: grants alternate with DONE + IDLE gaps.
        req = 2'b11; reachDest = 1'b1;
        src0 = 4'd1; dest0 = 4'd3; src1 = 4'd4; dest1 = 4'd6;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("rr_grant%0d", i), {30'd0, grant}, {30'd0, exp_g[i]});
            chk($sformatf("rr_done%0d", i), {30'd0, done}, {30'd0, exp_d[i]});
        end
        req = 2'b00;
        step(); step(); step();
        chk("rr_idle_busy", {31'd0, busy}, 32'd0);

        // Reset in the 3rd MOVE cycle; pointer returns to favour requester 0.
        req = 2'b11; reachDest = 1'b0;
        src0 = 4'd2; dest0 = 4'd7; src1 = 4'd4; dest1 = 4'd6;
        step();
        chk("mr_load_grant", {30'd0, grant}, 32'h2);
        step(); step(); step();
        chk("mr_move3", {29'd0, grant, gen_enable}, {29'd0, 2'b10, 1'b1});
        reset = 1'b1;
        step();
        chk("mr_reset_outs", outs(), 32'd0);
        reset = 1'b0;
        step();
        chk("mr_regrant", {22'd0, grant, gen_reset, gen_src, gen_dest}, {22'd0, 2'b01, 1'b1, 4'd2, 4'd7});
        reset = 1'b1; req = 2'b00;
        step();
        reset = 1'b0;

        // Requester drops req and changes src mid-move; move still completes.
        req = 2'b01; src0 = 4'd2; dest0 = 4'd7; reachDest = 1'b0;
        step(); step();
        req = 2'b00; src0 = 4'd5;
        step(); step();
        chk("drop_hold", {21'd0, grant, gen_enable, gen_src, gen_dest}, {21'd0, 2'b01, 1'b1, 4'd2, 4'd7});
        reachDest = 1'b1;
        step();
        chk("drop_done", {26'd0, done, gen_src}, {26'd0, 2'b01, 4'd2});
        reachDest = 1'b0;
        step();
        chk("drop_idle", {31'd0, busy}, 32'd0);

        // Stalled move: watchdog abort when enabled, indefinite wait otherwise.
        req = 2'b01; src0 = 4'd1; dest0 = 4'd2; reachDest = 1'b0;
        step();
`ifdef DMFB_ARB_WATCHDOG_EN
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("wd_move%0d", i), {29'd0, gen_enable, err}, {29'd0, 1'b1, 2'b00});
        end
        step();
        chk("wd_abort", {26'd0, err, grant, gen_enable, busy}, {26'd0, 2'b01, 2'b00, 1'b0, 1'b1});
        req = 2'b00;
        step();
        chk("wd_idle", {29'd0, err, busy}, 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("nowd_move%0d", i), {29'd0, gen_enable, err}, {29'd0, 1'b1, 2'b00});
        end
        reachDest = 1'b1;
        step();
        chk("nowd_done", {28'd0, done, err}, {28'd0, 2'b01, 2'b00});
        reachDest = 1'b0; req = 2'b00;
        step();
        chk("nowd_idle", {31'd0, busy}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
